// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - processor address/data/control bus seen by the UART transmitter
interface mmio_uart_tx_if;
    logic [7:0]  address_bus;
    logic [15:0] wdata_bus;
    logic [1:0]  control_bus;
    logic [15:0] io_rdata;
    logic        io_hit;

    modport master (
        output address_bus, wdata_bus, control_bus,
        input  io_rdata, io_hit
    );

    modport slave (
        input  address_bus, wdata_bus, control_bus,
        output io_rdata, io_hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with byte FIFO
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module mmio_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'hFE,
    parameter int         FIFO_DEPTH   = 8,
    parameter int         CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              nreset,
    mmio_uart_tx_if.slave     bus,
    output logic              tx,
    output logic              irq_empty
);
    localparam int              PTR_W       = $clog2(FIFO_DEPTH);
    localparam int              BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [4:0]      DEPTH_C     = 5'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      STAT_ADDR   = BASE_ADDR + 8'd1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]        count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              tx_q, tx_d;
    logic              irq_q, irq_d;
    logic              hit_q, hit_d;
    logic [15:0]       rdata_q, rdata_d;

    logic we, re, sel_data, sel_stat, full, busy, pop, push_req, push, rd_hit;
    logic unused_wdata_hi;

    assign we        = bus.control_bus[0];
    assign re        = bus.control_bus[1];
    assign sel_data  = (bus.address_bus == BASE_ADDR);
    assign sel_stat  = (bus.address_bus == STAT_ADDR);
    assign full      = (count_q == DEPTH_C);
    assign busy      = (state_q != S_IDLE);
    assign pop       = (state_q == S_IDLE) && (count_q != 5'd0);
    assign push_req  = we && sel_data;
    // A full FIFO still takes the byte when the serialiser frees a slot on the same edge.
    assign push      = push_req && (!full || pop);
    assign rd_hit    = re && !we && (sel_data || sel_stat);
    assign unused_wdata_hi = ^bus.wdata_bus[15:8];

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + 5'(push) - 5'(pop);
        overflow_d = overflow_q;
        if (we && sel_stat)
            overflow_d = 1'b0;
        else if (push_req && !push)
            overflow_d = 1'b1;
        hit_d   = rd_hit;
        rdata_d = (rd_hit && sel_stat) ? {8'h00, count_q, overflow_q, full, busy} : 16'h0000;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = (baud_q == '0) ? BAUD_RELOAD : baud_q - BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = BAUD_RELOAD;
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: if (baud_q == '0) begin
                state_d = S_DATA;
                bit_d   = 3'd0;
            end
            S_DATA: if (baud_q == '0) begin
                if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR:  if (baud_q == '0) state_d = S_STOP;
`endif
            S_STOP: if (baud_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // tx and irq_empty are registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PAR:   tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
        irq_d = (count_q == 5'd0) && !busy;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.wdata_bus[7:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= BAUD_RELOAD;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
            tx_q       <= 1'b1;
            irq_q      <= 1'b1;
            hit_q      <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
            tx_q       <= tx_d;
            irq_q      <= irq_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
        end
    end

    assign tx           = tx_q;
    assign irq_empty    = irq_q;
    assign bus.io_hit   = hit_q;
    assign bus.io_rdata = rdata_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with a behavioural serial receiver
module tb_mmio_uart_tx;
    localparam int         CLKS = 4;
    localparam logic [7:0] BASE = 8'hFE;
    localparam logic [7:0] STAT = 8'hFF;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CLKS;

    logic clk = 1'b0;
    logic nreset;
    logic tx, irq_empty;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus_if.slave),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rx_q[$];
    logic       rx_ok_q[$];
    logic [7:0] exp_q[$];

    // Expected line level of bit slot i in a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Receiver samples mid-bit and records each byte plus whether the framing was valid.
    initial begin : rx_model
        logic [7:0] d;
        logic       ok;
        forever begin
            @(posedge clk); #2;
            if (nreset === 1'b1 && tx === 1'b0) begin
                repeat (CLKS / 2) @(posedge clk);
                #2;
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(posedge clk);
                    #2;
                    d[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CLKS) @(posedge clk);
                #2;
                ok = ok && (tx === ^d);
`endif
                repeat (CLKS) @(posedge clk);
                #2;
                ok = ok && (tx === 1'b1);
                rx_q.push_back(d);
                rx_ok_q.push_back(ok);
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_if.address_bus = 8'h00;
        bus_if.wdata_bus   = 16'h0000;
        bus_if.control_bus = 2'b00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_if.address_bus = a;
        bus_if.wdata_bus   = {8'($urandom), d};
        bus_if.control_bus = 2'b01;
        cyc();
        idle_bus();
    endtask

    task automatic rd(input logic [7:0] a, output logic hit, output logic [15:0] data);
        bus_if.address_bus = a;
        bus_if.control_bus = 2'b10;
        cyc();
        idle_bus();
        hit  = bus_if.io_hit;
        data = bus_if.io_rdata;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (irq_empty !== 1'b1 && k < 2000) begin
            cyc();
            k++;
        end
        check("wait_idle", 16'(irq_empty), 16'h0001);
        repeat (2) cyc();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check("rx_count", 16'(rx_q.size()), 16'(n));
    endtask

    task automatic compare_rx();
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            check("rx_data", 16'(rx_q.pop_front()), 16'(exp_q.pop_front()));
            check("rx_frame", 16'(rx_ok_q.pop_front()), 16'h0001);
        end
        exp_q.delete();
        rx_q.delete();
        rx_ok_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic        hit;
        logic [15:0] data;
        logic [7:0]  b;
        logic        low_seen;
        int          n;

        idle_bus();
        nreset = 1'b1;
        #1 nreset = 1'b0;
        repeat (3) cyc();
        check("reset_tx", 16'(tx), 16'h0001);
        check("reset_irq", 16'(irq_empty), 16'h0001);
        check("reset_hit", 16'(bus_if.io_hit), 16'h0000);
        check("reset_rdata", bus_if.io_rdata, 16'h0000);
        nreset = 1'b1;
        repeat (20) cyc();
        check("idle_tx", 16'(tx), 16'h0001);
        check("idle_irq", 16'(irq_empty), 16'h0001);
        rd(STAT, hit, data);
        check("idle_stat_hit", 16'(hit), 16'h0001);
        check("idle_stat", data, 16'h0000);
        cyc();
        check("stat_hit_one_cycle", 16'(bus_if.io_hit), 16'h0000);

        // Single 0xA5 frame checked cycle by cycle including the two-edge start latency.
        wr(BASE, 8'hA5);
        check("a5_tx_at_write", 16'(tx), 16'h0001);
        cyc();
        check("a5_tx_lat1", 16'(tx), 16'h0001);
        cyc();
        check("a5_irq_busy", 16'(irq_empty), 16'h0000);
        for (int i = 0; i < FRAME; i++) begin
            check("a5_wave", 16'(tx), 16'(frame_bit(8'hA5, i / CLKS)));
            cyc();
        end
        check("a5_tx_after", 16'(tx), 16'h0001);
        exp_q.push_back(8'hA5);
        wait_rx(1, 100);
        compare_rx();
        wait_idle();
        rd(STAT, hit, data);
        check("a5_stat_after", data, 16'h0000);

        // Nine writes from idle all fit; the next two overflow.
        for (int k = 1; k <= 9; k++) begin
            wr(BASE, 8'(k));
            exp_q.push_back(8'(k));
        end
        wr(BASE, 8'hAA);
        wr(BASE, 8'hBB);
        rd(STAT, hit, data);
        check("ovf_hit", 16'(hit), 16'h0001);
        check("ovf_stat", data, {8'h00, 5'd8, 3'b111});
        cyc();
        check("ovf_hit_drop", 16'(bus_if.io_hit), 16'h0000);
        check("ovf_rdata_drop", bus_if.io_rdata, 16'h0000);
        wr(STAT, 8'h5A);
        rd(STAT, hit, data);
        check("ovf_clear", data, {8'h00, 5'd8, 3'b011});
        rd(8'h10, hit, data);
        check("miss_hit", 16'(hit), 16'h0000);
        check("miss_rdata", data, 16'h0000);
        rd(BASE, hit, data);
        check("data_rd_hit", 16'(hit), 16'h0001);
        check("data_rd_val", data, 16'h0000);
        bus_if.address_bus = STAT;
        bus_if.control_bus = 2'b11;
        cyc();
        idle_bus();
        check("we_re_hit", 16'(bus_if.io_hit), 16'h0000);
        wait_rx(9, 9 * (FRAME + 2) + 100);
        compare_rx();

        // Full FIFO plus a write on the exact edge the FSM pops.
        wait_idle();
        b = 8'($urandom);
        wr(BASE, b);
        exp_q.push_back(b);
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            wr(BASE, b);
            exp_q.push_back(b);
        end
        rd(STAT, hit, data);
        check("full_mid_hit", 16'(hit), 16'h0001);
        check("full_mid_stat", data, {8'h00, 5'd8, 3'b011});
        cyc();
        check("full_mid_hit_drop", 16'(bus_if.io_hit), 16'h0000);
        check("full_irq", 16'(irq_empty), 16'h0000);
        repeat (FRAME + 2 - 1 - 10) cyc();
        b = 8'($urandom);
        wr(BASE, b);
        exp_q.push_back(b);
        rd(STAT, hit, data);
        check("pop_push_stat", data, {8'h00, 5'd8, 3'b011});
        wait_rx(10, 10 * (FRAME + 2) + 100);
        compare_rx();

        // Random bursts of up to nine bytes from idle.
        for (int r = 0; r < 3; r++) begin
            wait_idle();
            n = int'($urandom_range(1, 9));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                wr(BASE, b);
                exp_q.push_back(b);
            end
            rd(STAT, hit, data);
            check("rand_no_ovf", 16'(data[2]), 16'h0000);
            wait_rx(n, n * (FRAME + 2) + 100);
            compare_rx();
        end

        // Reset asserted during data bit 3 of a frame with more bytes queued.
        wait_idle();
        b = 8'($urandom);
        wr(BASE, b);
        for (int k = 0; k < 3; k++) wr(BASE, 8'($urandom));
        repeat (16) cyc();
        check("rst_mid_bit3", 16'(tx), 16'(b[3]));
        #1 nreset = 1'b0;
        #1;
        check("rst_async_tx", 16'(tx), 16'h0001);
        check("rst_async_irq", 16'(irq_empty), 16'h0001);
        repeat (2) cyc();
        nreset = 1'b1;
        rd(STAT, hit, data);
        check("rst_stat", data, 16'h0000);
        low_seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            cyc();
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("rst_no_frames", 16'(low_seen), 16'h0000);
        rx_q.delete();
        rx_ok_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
